fb_port_scheduler: RTL and testbench

- Time-shares the single-port 320x240x8 frame-buffer BRAM between VGA readout and drawing-pipeline writes.
- Generates scaled readout addresses from 640x480 VGA counters (2x2 pixel doubling) and delays the sync/blank signals to match BRAM latency.
- Presents the 8-bit scaled pixel to the downstream VGA colour mux.
- Buffers pen/camera writes in a small FIFO and drains them only in cycles the display does not need the port.

---
 rtl/fb_port_scheduler.sv | 163 ++++++++++++++++
 tb/tb_fb_port_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_scheduler.sv
// Shares the single-port frame-buffer BRAM between 2x2-scaled VGA readout and a small
// FIFO of drawing writes; writes drain only in cycles the display leaves free.
module fb_port_scheduler #(
    parameter int FB_WIDTH   = 320,
    parameter int FB_HEIGHT  = 240,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              blank_in,
    input  logic              wr_valid_in,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [7:0]        wr_data_in,
    output logic              wr_ready_out,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic              bram_we_out,
    output logic [7:0]        bram_din_out,
    input  logic [7:0]        bram_dout_in,
    output logic [7:0]        scaled_pixel_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              blank_out
);
    localparam int                PIPE      = RD_LATENCY + 2;
    localparam int                PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]    DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] FB_SIZE   = ADDR_W'(FB_WIDTH * FB_HEIGHT);
    localparam logic [ADDR_W-1:0] FB_W_VEC  = ADDR_W'(FB_WIDTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_entry_t;

    wr_entry_t         fifo_mem_q [FIFO_DEPTH];
    wr_entry_t         fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [7:0]        din_q, din_d;
    logic [7:0]        pixel_q, pixel_d;

    logic [PIPE-1:0]   hsync_pipe_q, hsync_pipe_d;
    logic [PIPE-1:0]   vsync_pipe_q, vsync_pipe_d;
    logic [PIPE-1:0]   blank_pipe_q, blank_pipe_d;
    logic [PIPE-2:0]   cap_pipe_q, cap_pipe_d;

    logic              read_slot, fifo_empty, fifo_full, push, pop, head_in_range;
    logic [ADDR_W-1:0] row, col, rd_addr;
    wr_entry_t         head;
    logic              unused_vcount_lsb;

    assign read_slot         = !blank_in && !hcount_in[0];
    assign fifo_empty        = (count_q == '0);
    assign fifo_full         = (count_q == DEPTH_CNT);
    assign push              = wr_valid_in && !fifo_full;
    assign pop               = !read_slot && !fifo_empty;
    assign head              = fifo_mem_q[rd_ptr_q];
    assign head_in_range     = (head.addr < FB_SIZE);
    assign row               = ADDR_W'(vcount_in[9:1]);
    assign col               = ADDR_W'(hcount_in[10:1]);
    assign unused_vcount_lsb = vcount_in[0];

    // Row times frame-buffer width, folded into constant shift-adds over the set bits of FB_WIDTH.
    always_comb begin
        rd_addr = col;
        for (int i = 0; i < ADDR_W; i++) begin
            if (FB_W_VEC[i]) rd_addr = rd_addr + (row << i);
        end
    end

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        din_d      = din_q;

        // A popped out-of-range entry still consumes its free slot but never reaches the BRAM.
        if (read_slot) begin
            addr_d = rd_addr;
        end else if (pop && head_in_range) begin
            addr_d = head.addr;
            din_d  = head.data;
            we_d   = 1'b1;
        end

        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = '{addr: wr_addr_in, data: wr_data_in};
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        hsync_pipe_d = {hsync_pipe_q[PIPE-2:0], hsync_in};
        vsync_pipe_d = {vsync_pipe_q[PIPE-2:0], vsync_in};
        blank_pipe_d = {blank_pipe_q[PIPE-2:0], blank_in};
        cap_pipe_d   = {cap_pipe_q[PIPE-3:0], read_slot};

        pixel_d = pixel_q;
        if (blank_pipe_q[PIPE-2]) begin
            pixel_d = '0;
        end else if (cap_pipe_q[PIPE-2]) begin
            pixel_d = bram_dout_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            din_q        <= '0;
            pixel_q      <= '0;
            hsync_pipe_q <= '1;
            vsync_pipe_q <= '1;
            blank_pipe_q <= '1;
            cap_pipe_q   <= '0;
        end else begin
            fifo_mem_q   <= fifo_mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            din_q        <= din_d;
            pixel_q      <= pixel_d;
            hsync_pipe_q <= hsync_pipe_d;
            vsync_pipe_q <= vsync_pipe_d;
            blank_pipe_q <= blank_pipe_d;
            cap_pipe_q   <= cap_pipe_d;
        end
    end

    assign wr_ready_out     = !fifo_full;
    assign bram_addr_out    = addr_q;
    assign bram_we_out      = we_q;
    assign bram_din_out     = din_q;
    assign scaled_pixel_out = pixel_q;
    assign hsync_out        = hsync_pipe_q[PIPE-1];
    assign vsync_out        = vsync_pipe_q[PIPE-1];
    assign blank_out        = blank_pipe_q[PIPE-1];

endmodule

// File: tb/tb_fb_port_scheduler.sv
// Directed and randomized checks of fb_port_scheduler against a queue-based reference
// model, with a two-cycle-latency BRAM model attached to the port.
`timescale 1ns/1ps
module tb_fb_port_scheduler;
    localparam int FB_W    = 320;
    localparam int FB_SIZE = 76800;
    localparam int DEPTH   = 16;
    localparam int PIPE    = 4;

    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        hsync_in, vsync_in, blank_in;
    logic        wr_valid_in;
    logic [16:0] wr_addr_in;
    logic [7:0]  wr_data_in;
    logic        wr_ready_out;
    logic [16:0] bram_addr_out;
    logic        bram_we_out;
    logic [7:0]  bram_din_out;
    logic [7:0]  bram_dout_in = 8'h00;
    logic [7:0]  scaled_pixel_out;
    logic        hsync_out, vsync_out, blank_out;

    fb_port_scheduler dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .hcount_in        (hcount_in),
        .vcount_in        (vcount_in),
        .hsync_in         (hsync_in),
        .vsync_in         (vsync_in),
        .blank_in         (blank_in),
        .wr_valid_in      (wr_valid_in),
        .wr_addr_in       (wr_addr_in),
        .wr_data_in       (wr_data_in),
        .wr_ready_out     (wr_ready_out),
        .bram_addr_out    (bram_addr_out),
        .bram_we_out      (bram_we_out),
        .bram_din_out     (bram_din_out),
        .bram_dout_in     (bram_dout_in),
        .scaled_pixel_out (scaled_pixel_out),
        .hsync_out        (hsync_out),
        .vsync_out        (vsync_out),
        .blank_out        (blank_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] initVal(input int a);
        return 8'((a * 29) ^ (a >> 7));
    endfunction

    // BRAM model: port sampled mid-cycle, read data emerges two clocks after the address.
    logic [7:0]  bram [0:131071];
    logic [7:0]  bram_r1 = 8'h00;
    logic [16:0] s_addr;
    logic        s_we;
    logic [7:0]  s_din;
    initial begin
        for (int i = 0; i < 131072; i++) bram[i] = initVal(i);
        forever begin
            @(negedge clk_in);
            s_addr = bram_addr_out;
            s_we   = bram_we_out;
            s_din  = bram_din_out;
            @(posedge clk_in);
            bram_dout_in <= bram_r1;
            bram_r1      <= bram[s_addr];
            if (s_we) bram[s_addr] = s_din;
        end
    end

    // Reference model state
    logic [7:0]  ref_mem [0:131071];
    wr_t         m_fifo[$];
    logic        hs_hist[$], vs_hist[$], bl_hist[$];
    int          px_hist[$];
    logic [16:0] m_addr;
    logic        m_we;
    logic [7:0]  m_din, m_pix;
    logic        e_hs, e_vs, e_bl;
    logic        last_accept;
    logic [16:0] wr_addrs[$];

    int n_total, n_pass, n_fail;
    int accepted, writes;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_fifo.delete();
        hs_hist.delete(); vs_hist.delete(); bl_hist.delete(); px_hist.delete();
        for (int i = 0; i < PIPE - 1; i++) begin
            hs_hist.push_back(1'b1);
            vs_hist.push_back(1'b1);
            bl_hist.push_back(1'b1);
            px_hist.push_back(-2);
        end
        m_addr = '0; m_we = 1'b0; m_din = '0; m_pix = '0;
    endtask

    // One clock of the scheduling rules: even active pixels read, otherwise drain one write.
    task automatic modelStep();
        wr_t  e;
        logic rd;
        int   px;
        rd          = !blank_in && !hcount_in[0];
        last_accept = wr_valid_in && (m_fifo.size() < DEPTH);
        m_we        = 1'b0;
        if (rd) begin
            m_addr = 17'((int'(vcount_in) / 2) * FB_W + int'(hcount_in) / 2);
        end else if (m_fifo.size() > 0) begin
            e = m_fifo.pop_front();
            if (int'(e.addr) < FB_SIZE) begin
                m_addr = e.addr;
                m_din  = e.data;
                m_we   = 1'b1;
                ref_mem[e.addr] = e.data;
            end
        end
        if (last_accept) m_fifo.push_back('{addr: wr_addr_in, data: wr_data_in});
        if (blank_in) px = -2;
        else if (rd)  px = int'(ref_mem[m_addr]);
        else          px = -1;
        hs_hist.push_back(hsync_in); e_hs = hs_hist.pop_front();
        vs_hist.push_back(vsync_in); e_vs = vs_hist.pop_front();
        bl_hist.push_back(blank_in); e_bl = bl_hist.pop_front();
        px_hist.push_back(px);       px   = px_hist.pop_front();
        if (px == -2)     m_pix = 8'h00;
        else if (px >= 0) m_pix = 8'(px);
    endtask

    // Drive one cycle of inputs at the falling edge, advance a clock, compare at the next falling edge.
    task automatic applyStimulus(input int h, input int v, input bit hs, input bit vs, input bit bl,
                                 input bit wv, input int wa, input int wd);
        hcount_in   = 11'(h);
        vcount_in   = 10'(v);
        hsync_in    = hs;
        vsync_in    = vs;
        blank_in    = bl;
        wr_valid_in = wv;
        wr_addr_in  = 17'(wa);
        wr_data_in  = 8'(wd);
        checkOutput("wr_ready", 32'(wr_ready_out), 32'(m_fifo.size() < DEPTH));
        modelStep();
        if (last_accept) accepted++;
        @(posedge clk_in);
        @(negedge clk_in);
        if (bram_we_out === 1'b1) begin
            writes++;
            wr_addrs.push_back(bram_addr_out);
        end
        checkOutput("bram_we", 32'(bram_we_out), 32'(m_we));
        checkOutput("bram_addr", 32'(bram_addr_out), 32'(m_addr));
        if (m_we) checkOutput("bram_din", 32'(bram_din_out), 32'(m_din));
        checkOutput("pixel", 32'(scaled_pixel_out), 32'(m_pix));
        checkOutput("hsync_out", 32'(hsync_out), 32'(e_hs));
        checkOutput("vsync_out", 32'(vsync_out), 32'(e_vs));
        checkOutput("blank_out", 32'(blank_out), 32'(e_bl));
    endtask

    // Directed scenarios followed by a randomized run, all in one linear sequence.
    initial begin
        n_total = 0; n_pass = 0; n_fail = 0; accepted = 0; writes = 0;
        for (int i = 0; i < 131072; i++) ref_mem[i] = initVal(i);
        rst_n_in = 1'b0;
        hcount_in = 11'd100; vcount_in = 10'd50;
        hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b0;
        wr_valid_in = 1'b1; wr_addr_in = 17'd5; wr_data_in = 8'h12;
        modelReset();

        // Reset held mid-frame
        repeat (3) @(negedge clk_in);
        checkOutput("rst_addr", 32'(bram_addr_out), 32'd0);
        checkOutput("rst_we", 32'(bram_we_out), 32'd0);
        checkOutput("rst_din", 32'(bram_din_out), 32'd0);
        checkOutput("rst_pixel", 32'(scaled_pixel_out), 32'd0);
        checkOutput("rst_hsync", 32'(hsync_out), 32'd1);
        checkOutput("rst_vsync", 32'(vsync_out), 32'd1);
        checkOutput("rst_blank", 32'(blank_out), 32'd1);
        checkOutput("rst_ready", 32'(wr_ready_out), 32'd1);
        wr_valid_in = 1'b0;
        rst_n_in    = 1'b1;
        modelReset();
        applyStimulus(100, 50, 1, 1, 1, 0, 0, 0);
        applyStimulus(10, 4, 1, 1, 0, 0, 0, 0);
        checkOutput("first_rd_addr", 32'(bram_addr_out), 32'd645);

        // Readout: place 0xC0 at fb address 321 through the write path, then display it
        applyStimulus(0, 0, 1, 1, 1, 1, 321, 'hC0);
        applyStimulus(0, 0, 1, 1, 1, 0, 0, 0);
        applyStimulus(2, 2, 0, 1, 0, 0, 0, 0);
        checkOutput("rd_addr_321", 32'(bram_addr_out), 32'd321);
        applyStimulus(3, 2, 1, 1, 0, 0, 0, 0);
        applyStimulus(4, 2, 1, 1, 0, 0, 0, 0);
        checkOutput("blank_lag_t3", 32'(blank_out), 32'd1);
        applyStimulus(5, 2, 1, 1, 0, 0, 0, 0);
        checkOutput("pixel_t4", 32'(scaled_pixel_out), 32'hC0);
        checkOutput("hsync_lag_t4", 32'(hsync_out), 32'd0);
        checkOutput("blank_lag_t4", 32'(blank_out), 32'd0);
        applyStimulus(6, 2, 1, 1, 0, 0, 0, 0);
        checkOutput("pixel_t5", 32'(scaled_pixel_out), 32'hC0);
        checkOutput("hsync_lag_t5", 32'(hsync_out), 32'd1);
        applyStimulus(7, 2, 1, 1, 0, 0, 0, 0);

        // Interleave writes into an active line
        wr_addrs.delete();
        for (int h = 20; h < 40; h++) begin
            case (h)
                20:      applyStimulus(h, 10, 1, 1, 0, 1, 10, 'h3F);
                21:      applyStimulus(h, 10, 1, 1, 0, 1, 11, 'hEA);
                22:      applyStimulus(h, 10, 1, 1, 0, 1, 12, 'h00);
                default: applyStimulus(h, 10, 1, 1, 0, 0, 0, 0);
            endcase
        end
        checkOutput("ilv_count", 32'(wr_addrs.size()), 32'd3);
        if (wr_addrs.size() == 3) begin
            checkOutput("ilv_addr0", 32'(wr_addrs[0]), 32'd10);
            checkOutput("ilv_addr1", 32'(wr_addrs[1]), 32'd11);
            checkOutput("ilv_addr2", 32'(wr_addrs[2]), 32'd12);
        end

        // Full: every cycle a read slot, 20 write attempts
        accepted = 0;
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, 1, 0, 1, 2000 + i, $urandom);
        checkOutput("full_accepted", 32'(accepted), 32'd16);
        checkOutput("full_ready", 32'(wr_ready_out), 32'd0);
        writes = 0;
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 1, 1, 0, 0, 0);
        checkOutput("full_drain_writes", 32'(writes), 32'd16);
        checkOutput("full_drain_ready", 32'(wr_ready_out), 32'd1);

        // Simultaneous push/pop at occupancy 15
        for (int i = 0; i < 15; i++) applyStimulus(0, 0, 1, 1, 0, 1, 3000 + i, $urandom);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 1, 1, 1, 1, 3100 + i, $urandom);
        accepted = 0;
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0, 1, 3200 + i, $urandom);
        checkOutput("pp_accepted", 32'(accepted), 32'd1);
        for (int i = 0; i < 17; i++) applyStimulus(0, 0, 1, 1, 1, 0, 0, 0);
        checkOutput("pp_ready", 32'(wr_ready_out), 32'd1);

        // Out-of-range address dropped at pop
        applyStimulus(0, 0, 1, 1, 1, 1, 76800, 'h55);
        applyStimulus(0, 0, 1, 1, 1, 1, 76799, 'h66);
        checkOutput("range_drop_we", 32'(bram_we_out), 32'd0);
        applyStimulus(0, 0, 1, 1, 1, 0, 0, 0);
        checkOutput("range_ok_we", 32'(bram_we_out), 32'd1);
        checkOutput("range_ok_addr", 32'(bram_addr_out), 32'd76799);
        checkOutput("range_ok_din", 32'(bram_din_out), 32'h66);

        // Reset while draining 8 queued writes
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 1, 0, 1, 4000 + i, $urandom);
        applyStimulus(0, 0, 1, 1, 1, 0, 0, 0);
        checkOutput("drain_active", 32'(bram_we_out), 32'd1);
        rst_n_in = 1'b0;
        #1;
        checkOutput("middrain_we", 32'(bram_we_out), 32'd0);
        checkOutput("middrain_ready", 32'(wr_ready_out), 32'd1);
        checkOutput("middrain_addr", 32'(bram_addr_out), 32'd0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        modelReset();
        writes = 0;
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, 1, 1, 0, 0, 0);
        checkOutput("post_rst_writes", 32'(writes), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) == 0) ? int'($urandom_range(76800, 131071))
                                                      : int'($urandom_range(0, 76799)),
                          int'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
